// File: rtl/store_narrow_buffer.sv
// Narrows GPR stores to sb/sh/sw lanes and queues them in a DEPTH-entry FIFO; 1-cycle accept-to-output latency.
// Backpressure: st_ready drops when full (no pass-through); head entry held stable while mem_ready is low.
module store_narrow_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        ades,
    output logic [31:0] bad_vaddr,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic [29:0] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [3:0]  be_q    [DEPTH];

    logic        legal;
    logic [3:0]  nar_be;
    logic [31:0] nar_wdata;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        legal     = 1'b0;
        nar_be    = 4'b0000;
        nar_wdata = st_data;
        case (st_type)
            2'b00: begin
                legal     = (st_addr[1:0] == 2'b00);
                nar_be    = 4'b1111;
                nar_wdata = st_data;
            end
            2'b01: begin
                legal     = ~st_addr[0];
                nar_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                nar_wdata = {2{st_data[15:0]}};
            end
            2'b10: begin
                legal     = 1'b1;
                nar_be    = 4'b0001 << st_addr[1:0];
                nar_wdata = {4{st_data[7:0]}};
            end
            default: begin
                legal     = 1'b0;
                nar_be    = 4'b0000;
                nar_wdata = st_data;
            end
        endcase
    end

    // Status outputs come straight from count so an async reset shows up immediately.
    assign st_ready  = (count < FULL_CNT);
    assign mem_valid = (count != '0);
    assign empty     = (count == '0);

    assign accept = st_valid && st_ready;
    assign push   = accept && legal;
    assign pop    = mem_valid && mem_ready;

    assign mem_addr  = {addr_q[rd_ptr], 2'b00};
    assign mem_wdata = wdata_q[rd_ptr];
    assign mem_be    = be_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            ades      <= 1'b0;
            bad_vaddr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            ades <= accept && !legal;
            if (accept && !legal)
                bad_vaddr <= st_addr;
        end
    end

    // Payload storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= st_addr[31:2];
            wdata_q[wr_ptr] <= nar_wdata;
            be_q[wr_ptr]    <= nar_be;
        end
    end

endmodule
